// File: rtl/switch_pkg.sv
// Shared types, defaults and width helpers for the queued output switch.
package switch_pkg;

    localparam int unsigned WIDTH_DEF = 64;
    localparam int unsigned PORTS_DEF = 16;
    localparam int unsigned DEPTH_DEF = 4;

    // Destination mask at the default port count.
    typedef logic [PORTS_DEF-1:0] port_mask_t;

    // Width of the unicast select field; at least one bit.
    function automatic int unsigned sel_w(input int unsigned ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // Width of an occupancy counter that can hold 0..depth inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/switch_queued_if.sv
// Input/output bundle of the queued switch.
//   master : lookup-side producer and egress consumers (drives in_*, found,
//            select, broadcast, out_ready)
//   slave  : the switch itself
// With SWITCH_QUEUED_STATS_EN defined the bundle also carries tx_count and
// drop_count.
interface switch_queued_if
    import switch_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned PORTS = PORTS_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
);
    localparam int unsigned SEL_W = sel_w(PORTS);
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     data_in;
    logic                 found;
    logic [SEL_W-1:0]     select;
    logic [PORTS-1:0]     broadcast;
    logic [PORTS-1:0]     out_valid;
    logic [PORTS-1:0]     out_ready;
    logic [WIDTH-1:0]     data_out   [PORTS];
    logic [LVL_W-1:0]     fill_level [PORTS];
`ifdef SWITCH_QUEUED_STATS_EN
    logic [31:0]          tx_count   [PORTS];
    logic [31:0]          drop_count;
`endif

    modport master (
        output in_valid, data_in, found, select, broadcast, out_ready,
        input  in_ready, out_valid, data_out, fill_level
`ifdef SWITCH_QUEUED_STATS_EN
        , input tx_count, drop_count
`endif
    );

    modport slave (
        input  in_valid, data_in, found, select, broadcast, out_ready,
        output in_ready, out_valid, data_out, fill_level
`ifdef SWITCH_QUEUED_STATS_EN
        , output tx_count, drop_count
`endif
    );

endinterface

// File: rtl/sw_port_fifo.sv
// Single-port synchronous FIFO used as one output queue of the switch.
// Ports: clk, rst_n (sync, active-low), push/din, pop/dout (head word),
//        full, empty, level (0..DEPTH).
// Push is ignored when full and pop when empty; push+pop together keeps the
// level unchanged.
module sw_port_fifo
    import switch_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [lvl_w(DEPTH)-1:0]  level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage, pointers (wrap naturally, DEPTH is a power of two) and level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + LVL_W'(1);
                2'b01:   cnt <= cnt - LVL_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign full  = (cnt == LVL_W'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/switch_queued.sv
// Queued output switch: routes one input word per cycle to a unicast port
// (found + select) or a multicast mask (broadcast), each port owning a FIFO.
// Ports: clk, rst_n (sync, active-low), bus (switch_queued_if.slave).
// Optional: SWITCH_QUEUED_STATS_EN adds saturating per-port pop counters and
// a drop counter on the bus.
module switch_queued
    import switch_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned PORTS = PORTS_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    switch_queued_if.slave  bus
);
    logic [PORTS-1:0] mask_c;
    logic [PORTS-1:0] full;
    logic [PORTS-1:0] empty;
    logic [PORTS-1:0] push;
    logic [PORTS-1:0] pop;
    logic             accept;

    // Destination decode; an out-of-range select matches no port (drop).
    always_comb begin
        mask_c = '0;
        for (int p = 0; p < int'(PORTS); p++) begin
            mask_c[p] = bus.found ? (32'(bus.select) == 32'(p)) : bus.broadcast[p];
        end
    end

    // Ready only when every targeted queue has room, so multicast is atomic.
    assign bus.in_ready  = &(~mask_c | ~full);
    assign accept        = bus.in_valid & bus.in_ready;
    assign push          = {PORTS{accept}} & mask_c;
    assign bus.out_valid = ~empty;
    assign pop           = bus.out_valid & bus.out_ready;

    for (genvar g = 0; g < int'(PORTS); g++) begin : g_port
        sw_port_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (bus.data_in),
            .dout  (bus.data_out[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .level (bus.fill_level[g])
        );
    end

`ifdef SWITCH_QUEUED_STATS_EN
    logic [31:0] tx_q [PORTS];
    logic [31:0] drop_q;

    // Saturating traffic counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= '0;
            for (int p = 0; p < int'(PORTS); p++) begin
                tx_q[p] <= '0;
            end
        end else begin
            if (accept && (mask_c == '0) && (drop_q != '1)) begin
                drop_q <= drop_q + 32'd1;
            end
            for (int p = 0; p < int'(PORTS); p++) begin
                if (pop[p] && (tx_q[p] != '1)) begin
                    tx_q[p] <= tx_q[p] + 32'd1;
                end
            end
        end
    end

    assign bus.tx_count   = tx_q;
    assign bus.drop_count = drop_q;
`endif

endmodule

// File: tb/tb_switch_queued.sv
// Directed bench for switch_queued: a 16-port instance for the main plan and
// a 12-port instance for the out-of-range select case.
module tb_switch_queued;
    import switch_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    switch_queued_if #(.WIDTH(64), .PORTS(16), .DEPTH(4)) b   ();
    switch_queued_if #(.WIDTH(64), .PORTS(12), .DEPTH(4)) b12 ();

    switch_queued #(.WIDTH(64), .PORTS(16), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    switch_queued #(.WIDTH(64), .PORTS(12), .DEPTH(4)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        port_mask_t mc;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        b.in_valid = 1'b0;  b.data_in = '0; b.found = 1'b0; b.select = '0;
        b.broadcast = '0;   b.out_ready = '0;
        b12.in_valid = 1'b0; b12.data_in = '0; b12.found = 1'b0; b12.select = '0;
        b12.broadcast = '0;  b12.out_ready = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_valid", 64'(b.out_valid), 64'h0);
        chk("rst_in_ready", 64'(b.in_ready), 64'h1);
        chk("rst_fill3", 64'(b.fill_level[3]), 64'd0);
        chk("rst_data0", b.data_out[0], 64'h0);

        // 1. Unicast fill on port 3, then drain
        b.found = 1'b1; b.select = 4'd3; b.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b.data_in = 64'hA0 + 64'(i);
            chk("t1_ready_fill", 64'(b.in_ready), 64'h1);
            tick();
        end
        chk("t1_level_full", 64'(b.fill_level[3]), 64'd4);
        chk("t1_head_a0", b.data_out[3], 64'hA0);
        b.data_in = 64'hA4;
        chk("t1_ready_full", 64'(b.in_ready), 64'h0);
        tick();
        chk("t1_level_held", 64'(b.fill_level[3]), 64'd4);
        chk("t1_ready_still0", 64'(b.in_ready), 64'h0);
        b.out_ready[3] = 1'b1;
        chk("t1_ready_no_thru", 64'(b.in_ready), 64'h0);
        tick();
        chk("t1_lvl_after_pop", 64'(b.fill_level[3]), 64'd3);
        chk("t1_ready_after_pop", 64'(b.in_ready), 64'h1);
        chk("t1_head_a1", b.data_out[3], 64'hA1);
        tick();
        b.in_valid = 1'b0;
        chk("t1_lvl_pushpop", 64'(b.fill_level[3]), 64'd3);
        chk("t1_head_a2", b.data_out[3], 64'hA2);
        tick();
        chk("t1_head_a3", b.data_out[3], 64'hA3);
        tick();
        chk("t1_head_a4", b.data_out[3], 64'hA4);
        chk("t1_lvl_1", 64'(b.fill_level[3]), 64'd1);
        tick();
        chk("t1_empty", 64'(b.out_valid[3]), 64'h0);
        chk("t1_lvl_0", 64'(b.fill_level[3]), 64'd0);
        b.out_ready = '0;

        // 2. Multicast atomicity with port 4 full
        b.found = 1'b1; b.select = 4'd4; b.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b.data_in = 64'hB0 + 64'(i);
            tick();
        end
        mc = 16'h0011;
        b.found = 1'b0; b.broadcast = mc; b.data_in = 64'hC0;
        chk("t2_ready_blocked", 64'(b.in_ready), 64'h0);
        tick();
        chk("t2_no_write_p0", 64'(b.fill_level[0]), 64'd0);
        chk("t2_no_write_p4", 64'(b.fill_level[4]), 64'd4);
        b.out_ready[4] = 1'b1;
        tick();
        b.out_ready = '0;
        chk("t2_ready_room", 64'(b.in_ready), 64'h1);
        chk("t2_p0_still_empty", 64'(b.fill_level[0]), 64'd0);
        tick();
        b.in_valid = 1'b0;
        chk("t2_p0_level", 64'(b.fill_level[0]), 64'd1);
        chk("t2_p4_level", 64'(b.fill_level[4]), 64'd4);
        chk("t2_p0_head", b.data_out[0], 64'hC0);
        chk("t2_p4_head", b.data_out[4], 64'hB1);
        b.out_ready = 16'h0011;
        tick(); tick(); tick();
        chk("t2_p4_tail", b.data_out[4], 64'hC0);
        chk("t2_p4_lvl1", 64'(b.fill_level[4]), 64'd1);
        chk("t2_p0_drained", 64'(b.fill_level[0]), 64'd0);
        tick();
        chk("t2_p4_drained", 64'(b.fill_level[4]), 64'd0);
        b.out_ready = '0;

        // 3. Latency and hold on port 7
        b.found = 1'b1; b.select = 4'd7; b.data_in = 64'hDEADBEEF; b.in_valid = 1'b1;
        chk("t3_no_bypass", 64'(b.out_valid[7]), 64'h0);
        tick();
        b.in_valid = 1'b0;
        chk("t3_valid_n", 64'(b.out_valid[7]), 64'h1);
        chk("t3_data_n", b.data_out[7], 64'hDEADBEEF);
        tick();
        chk("t3_hold1", b.data_out[7], 64'hDEADBEEF);
        tick();
        chk("t3_hold2", b.data_out[7], 64'hDEADBEEF);
        chk("t3_hold2_valid", 64'(b.out_valid[7]), 64'h1);
        b.out_ready[7] = 1'b1;
        tick();
        b.out_ready = '0;
        chk("t3_popped", 64'(b.out_valid[7]), 64'h0);
        chk("t3_lvl0", 64'(b.fill_level[7]), 64'd0);

        // 4. Simultaneous push/pop on port 2 across pointer wrap
        b.found = 1'b1; b.select = 4'd2; b.in_valid = 1'b1;
        b.data_in = 64'hD0; tick();
        b.data_in = 64'hD1; tick();
        b.out_ready[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b.data_in = 64'hD0 + 64'(i + 2);
            chk("t4_head", b.data_out[2], 64'hD0 + 64'(i));
            chk("t4_level", 64'(b.fill_level[2]), 64'd2);
            tick();
        end
        b.in_valid = 1'b0;
        chk("t4_head_end", b.data_out[2], 64'hDA);
        chk("t4_level_end", 64'(b.fill_level[2]), 64'd2);
        tick();
        chk("t4_head_last", b.data_out[2], 64'hDB);
        tick();
        chk("t4_drained", 64'(b.fill_level[2]), 64'd0);
        b.out_ready = '0;

        // 5. Drop, then reset with words queued
        b.found = 1'b1; b.select = 4'd5; b.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b.data_in = 64'hF0 + 64'(i);
            tick();
        end
        b.found = 1'b0; b.broadcast = '0; b.data_in = 64'hE0;
        chk("t5_drop_ready", 64'(b.in_ready), 64'h1);
        tick();
        b.in_valid = 1'b0;
        chk("t5_drop_p5", 64'(b.fill_level[5]), 64'd3);
        chk("t5_drop_p0", 64'(b.fill_level[0]), 64'd0);
        chk("t5_drop_valid", 64'(b.out_valid), 64'h0020);
`ifdef SWITCH_QUEUED_STATS_EN
        chk("t5_drop_count", 64'(b.drop_count), 64'd1);
        chk("t5_tx3", 64'(b.tx_count[3]), 64'd5);
        chk("t5_tx4", 64'(b.tx_count[4]), 64'd5);
        chk("t5_tx0", 64'(b.tx_count[0]), 64'd1);
        chk("t5_tx2", 64'(b.tx_count[2]), 64'd12);
        chk("t5_tx7", 64'(b.tx_count[7]), 64'd1);
`endif
        rst_n = 1'b0;
        b.found = 1'b1; b.select = 4'd6; b.data_in = 64'h66; b.in_valid = 1'b1;
        tick();
        chk("t5_rst_valid", 64'(b.out_valid), 64'h0);
        chk("t5_rst_p5", 64'(b.fill_level[5]), 64'd0);
        chk("t5_rst_p6", 64'(b.fill_level[6]), 64'd0);
        chk("t5_rst_data5", b.data_out[5], 64'h0);
        chk("t5_rst_ready", 64'(b.in_ready), 64'h1);
`ifdef SWITCH_QUEUED_STATS_EN
        chk("t5_rst_drop", 64'(b.drop_count), 64'd0);
        chk("t5_rst_tx2", 64'(b.tx_count[2]), 64'd0);
`endif
        b.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t5_post_p6", 64'(b.fill_level[6]), 64'd0);

        // 6. Out-of-range select on the 12-port instance
        b12.found = 1'b1; b12.select = 4'd13; b12.data_in = 64'h13; b12.in_valid = 1'b1;
        chk("t6_ready", 64'(b12.in_ready), 64'h1);
        tick();
        chk("t6_no_valid", 64'(b12.out_valid), 64'h0);
        chk("t6_p1", 64'(b12.fill_level[1]), 64'd0);
        chk("t6_p5", 64'(b12.fill_level[5]), 64'd0);
`ifdef SWITCH_QUEUED_STATS_EN
        chk("t6_drop_count", 64'(b12.drop_count), 64'd1);
`endif
        b12.select = 4'd11; b12.data_in = 64'h11;
        tick();
        b12.in_valid = 1'b0;
        chk("t6_p11_level", 64'(b12.fill_level[11]), 64'd1);
        chk("t6_p11_data", b12.data_out[11], 64'h11);
        chk("t6_valid_vec", 64'(b12.out_valid), 64'h800);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_queued.md
Name: switch_queued

Overview:
- Parametrised successor to the single-cycle output switch.
- Routes one input word per cycle to a unicast port (`found` plus `select`) or to a multicast mask (`broadcast` vector, no longer reduced to "all ports").
- Each output port has its own FIFO with a valid/ready handshake. Output backpressure propagates to the input as `in_ready`.
- Sits between the lookup stage (which supplies `found` and `select`) and the per-port egress logic.

Parameters:
- `WIDTH`, 64, data word width in bits.
- `PORTS`, 16, number of output ports; must be ≥2.
- `DEPTH`, 4, entries per output FIFO; power of 2, ≥2.
- `SEL_W`, `$clog2(PORTS)`, width of `select`; derived, not overridden.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input can be accepted this cycle.
- `data_in`  in  `WIDTH`  input word.
- `found`  in  1  unicast lookup hit; `select` is valid.
- `select`  in  `SEL_W`  unicast destination port.
- `broadcast`  in  `PORTS`  multicast destination mask; used when `found`=0.
- `out_valid`  out  `PORTS`  per-port head word valid.
- `out_ready`  in  `PORTS`  per-port consumer ready.
- `data_out`  out  `PORTS` x `WIDTH`  unpacked array; per-port head word.
- `fill_level`  out  `PORTS` x `$clog2(DEPTH+1)`  per-port occupancy.

Behaviour:
- Target mask:
  - `found`=1: one-hot(`select`); `broadcast` is ignored.
  - `found`=0: `broadcast`.
  - `select` ≥ `PORTS`: mask = 0.
- `in_ready` is combinational: AND over all ports p of (!mask[p] | !full[p]).
  - Depends only on registered full flags and the current mask.
  - No ready-through from `out_ready`.
- Accept when `in_valid & in_ready`. The word is pushed into every FIFO in the mask in the same edge (atomic multicast). A partial write never occurs.
- Mask = 0 with `in_valid`=1: `in_ready`=1 and the word is consumed and discarded (drop).
- Pop on port p when `out_valid[p] & out_ready[p]`.
- Push and pop on the same port in the same cycle:
  - Occupancy is unchanged.
  - Legal at any level except full; no push can occur when full.
- Latency: a word accepted at edge N appears with `out_valid`=1 after edge N (one-cycle latency). There is no bypass path.
- `data_out[p]` stays stable while `out_valid[p]=1` and `out_ready[p]=0`. `data_out[p]` is don't-care when `out_valid[p]`=0.
- Ordering is FIFO per port. Ports drain independently.
- Pointers wrap modulo `DEPTH`. `fill_level` ranges from 0 to `DEPTH` inclusive.
- Reset (`rst_n`=0 at an edge):
  - All pointers and levels go to 0, `out_valid`=0, `data_out`=0.
  - `in_ready` = 1 whenever the mask has no full port, i.e. 1 after reset.
  - Reset mid-transfer discards all queued words; nothing is accepted on the reset edge.

Optional Feature:
- Macro: `SWITCH_QUEUED_STATS_EN`.
- Defined: adds outputs `tx_count` (`PORTS` x 32) and `drop_count` (32).
  - `tx_count[p]` increments on each pop of port p.
  - `drop_count` increments on each accept with mask = 0.
  - Counters saturate at `32'hFFFFFFFF` and reset to 0.
- Undefined: the ports and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Package `switch_pkg`:
  - `SEL_W` and level-width helper functions.
  - `typedef` for the port mask.
  - Default constants for `WIDTH`, `PORTS` and `DEPTH`.
- Sub-module `sw_port_fifo`:
  - Single-port sync FIFO with push, pop, full, empty and level.
  - Instantiated `PORTS` times by a `generate` loop.
- Top-level holds mask decode, `in_ready`, stats counters.

Test Plan:
1. Unicast fill: `found`=1, `select`=3, 5 words A0..A4 pushed, `out_ready[3]`=0, `DEPTH`=4 → first 4 words accepted, `fill_level[3]`=4, `in_ready`=0 on the 5th. Then `out_ready[3]`=1 → A0..A3 emerge in order and A4 is accepted one cycle after the first pop.
2. Multicast atomicity: `found`=0, `broadcast`=16'h0011, port 4 full → `in_ready`=0 and neither FIFO is written. Drain one entry from port 4 → the word lands in ports 0 and 4 on the same edge.
3. Latency and hold: single word `64'hDEADBEEF` to port 7 at edge N → `out_valid[7]`=1 after N. It is held stable for 3 cycles with `out_ready[7]`=0, then pops on the 4th cycle.
4. Simultaneous push/pop: port 2 at level 2 with continuous push and pop for 10 cycles → level stays 2 and the data order is preserved across pointer wrap.
5. Drop and reset: `found`=0, `broadcast`=0 with `in_valid` → `in_ready`=1, all levels unchanged, `drop_count`=1 with STATS_EN. Assert `rst_n`=0 with 3 words queued → after the edge all `out_valid`=0 and levels = 0.
6. Out-of-range `select`: `PORTS`=12, `found`=1, `select`=13 → treated as a drop and no port is written.
